// File: rtl/if_fetch_pkg.sv
// Shared types, widths and defaults for the instruction-fetch stage.
// Holds the fetch FSM encoding and the instruction/address bus types.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W            = 32;
    localparam int unsigned INST_W                 = 32;
    localparam int unsigned ICACHE_ENTRIES_DEFAULT = 64;

    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [INST_W-1:0]      inst_bus_t;

    localparam inst_addr_bus_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_LOOKUP = 2'd0,
        FETCH_REQ    = 2'd1,
        FETCH_WAIT   = 2'd2
    } fetch_state_e;

    // Instruction/PC pair handed to the IF/ID register.
    typedef struct packed {
        inst_addr_bus_t pc;
        inst_bus_t      inst;
    } fetch_pair_t;

    // Sequential successor; wraps modulo 2^32 and keeps the low two bits.
    function automatic inst_addr_bus_t pc_next(input inst_addr_bus_t pc);
        return pc + INST_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache.
// Combinational lookup, registered write port, valid bits async-cleared on rst.
module icache_dm
    import if_fetch_pkg::*;
#(
    parameter int unsigned ENTRIES = ICACHE_ENTRIES_DEFAULT
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [$clog2(ENTRIES)-1:0]                  rd_idx,
    input  logic [INST_ADDR_W-$clog2(ENTRIES)-2-1:0]    rd_tag,
    output logic                                        hit_c,
    output inst_bus_t                                   rd_data_c,
    input  logic                                        wr_en,
    input  logic [$clog2(ENTRIES)-1:0]                  wr_idx,
    input  logic [INST_ADDR_W-$clog2(ENTRIES)-2-1:0]    wr_tag,
    input  inst_bus_t                                   wr_data
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_d  [ENTRIES];
    inst_bus_t          data_q [ENTRIES];
    inst_bus_t          data_d [ENTRIES];

    assign hit_c     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_c = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data storage needs no reset: every read is qualified by valid.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, looks up a direct-mapped icache and
// refills it from the memory controller on a miss; honours stall and redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned    ICACHE_ENTRIES = ICACHE_ENTRIES_DEFAULT,
    parameter inst_addr_bus_t RESET_PC       = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall_in,
    input  logic           branch_flag_in,
    input  inst_addr_bus_t branch_target_in,
    input  logic           mem_busy_in,
    input  logic           get_inst_in,
    input  inst_addr_bus_t inst_pc_in,
    input  inst_bus_t      inst_in,
    output logic           if_req_out,
    output inst_addr_bus_t addr_if_out,
    output inst_addr_bus_t pc_out,
    output inst_bus_t      inst_out,
    output logic           inst_valid_out,
    output logic           if_stall_req_out
);

    localparam int unsigned IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int unsigned TAG_W = INST_ADDR_W - IDX_W - 2;

    fetch_state_e   state_q, state_d;
    inst_addr_bus_t pc_q, pc_d;
    inst_addr_bus_t pending_pc_q, pending_pc_d;
    inst_addr_bus_t addr_if_q, addr_if_d;
    fetch_pair_t    out_q, out_d;
    logic           discard_q, discard_d;
    logic           if_req_q, if_req_d;
    logic           inst_valid_q, inst_valid_d;
    logic           if_stall_req_q, if_stall_req_d;

    logic             hit_c;
    inst_bus_t        rd_data_c;
    logic             cache_wr_en_c;
    logic             resp_c;
    logic             latch_c;
    logic [IDX_W-1:0] rd_idx_c, wr_idx_c;
    logic [TAG_W-1:0] rd_tag_c, wr_tag_c;

    assign rd_idx_c = pc_q[IDX_W+1:2];
    assign rd_tag_c = pc_q[INST_ADDR_W-1:IDX_W+2];
    assign wr_idx_c = pending_pc_q[IDX_W+1:2];
    assign wr_tag_c = pending_pc_q[INST_ADDR_W-1:IDX_W+2];

    icache_dm #(
        .ENTRIES (ICACHE_ENTRIES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx_c),
        .rd_tag    (rd_tag_c),
        .hit_c     (hit_c),
        .rd_data_c (rd_data_c),
        .wr_en     (cache_wr_en_c),
        .wr_idx    (wr_idx_c),
        .wr_tag    (wr_tag_c),
        .wr_data   (inst_in)
    );

    // Controller has latched our request / returned our instruction.
    assign latch_c = mem_busy_in && !get_inst_in && (inst_pc_in == pc_q);
    assign resp_c  = get_inst_in && (inst_pc_in == pending_pc_q);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        discard_d     = discard_q;
        out_d         = out_q;
        inst_valid_d  = stall_in ? inst_valid_q : 1'b0;
        cache_wr_en_c = 1'b0;

        case (state_q)
            FETCH_LOOKUP: begin
                if (!branch_flag_in) begin
                    if (!hit_c) begin
                        state_d = FETCH_REQ;
                    end else if (!stall_in) begin
                        out_d.pc     = pc_q;
                        out_d.inst   = rd_data_c;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_next(pc_q);
                    end
                end
            end
            FETCH_REQ: begin
                if (branch_flag_in) begin
                    state_d = FETCH_LOOKUP;
                end else if (latch_c) begin
                    state_d      = FETCH_WAIT;
                    pending_pc_d = pc_q;
                end
            end
            FETCH_WAIT: begin
                if (resp_c) begin
                    // Refill always lands; delivery only when nothing overrides it.
                    cache_wr_en_c = 1'b1;
                    state_d       = FETCH_LOOKUP;
                    discard_d     = 1'b0;
                    if (!branch_flag_in && !discard_q && !stall_in) begin
                        out_d.pc     = pending_pc_q;
                        out_d.inst   = inst_in;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_next(pending_pc_q);
                    end
                end else if (!mem_busy_in) begin
                    state_d   = branch_flag_in ? FETCH_LOOKUP : FETCH_REQ;
                    discard_d = 1'b0;
                end else if (branch_flag_in) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_LOOKUP;
            end
        endcase

        if (branch_flag_in) begin
            pc_d         = branch_target_in;
            inst_valid_d = 1'b0;
        end

        if_req_d       = (state_d == FETCH_REQ);
        addr_if_d      = if_req_d ? pc_d : addr_if_q;
        if_stall_req_d = (state_d != FETCH_LOOKUP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH_LOOKUP;
            pc_q           <= RESET_PC;
            pending_pc_q   <= '0;
            discard_q      <= 1'b0;
            out_q          <= '0;
            inst_valid_q   <= 1'b0;
            if_req_q       <= 1'b0;
            addr_if_q      <= '0;
            if_stall_req_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pending_pc_q   <= pending_pc_d;
            discard_q      <= discard_d;
            out_q          <= out_d;
            inst_valid_q   <= inst_valid_d;
            if_req_q       <= if_req_d;
            addr_if_q      <= addr_if_d;
            if_stall_req_q <= if_stall_req_d;
        end
    end

    assign if_req_out       = if_req_q;
    assign addr_if_out      = addr_if_q;
    assign pc_out           = out_q.pc;
    assign inst_out         = out_q.inst;
    assign inst_valid_out   = inst_valid_q;
    assign if_stall_req_out = if_stall_req_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a memory-controller model plus a program-order
// scoreboard (expected next PC, memory image) checked after every clock.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        branch_flag_in;
    logic [31:0] branch_target_in;
    logic        mem_busy_in;
    logic        get_inst_in;
    logic [31:0] inst_pc_in;
    logic [31:0] inst_in;
    logic        if_req_out;
    logic [31:0] addr_if_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid_out;
    logic        if_stall_req_out;

    if_fetch #(.ICACHE_ENTRIES(64), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall_in),
        .branch_flag_in   (branch_flag_in),
        .branch_target_in (branch_target_in),
        .mem_busy_in      (mem_busy_in),
        .get_inst_in      (get_inst_in),
        .inst_pc_in       (inst_pc_in),
        .inst_in          (inst_in),
        .if_req_out       (if_req_out),
        .addr_if_out      (addr_if_out),
        .pc_out           (pc_out),
        .inst_out         (inst_out),
        .inst_valid_out   (inst_valid_out),
        .if_stall_req_out (if_stall_req_out)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          deliveries = 0;
    logic [31:0] exp_pc = 32'h0;

    // Controller model: 0 idle, 1 serving, 2 presenting the response.
    int          ctl_mode = 0;
    int          ctl_cnt = 0;
    int          ctl_lat = 5;
    int          arb_block = 0;
    bit          rand_arb = 1'b0;
    logic [31:0] ctl_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h0000_0013;
        return (pc * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic controller();
        if (rst) begin
            ctl_mode = 0; arb_block = 0;
            mem_busy_in = 1'b0; get_inst_in = 1'b0; inst_pc_in = 32'h0; inst_in = 32'h0;
            return;
        end
        if (ctl_mode == 2) begin
            ctl_mode = 0; mem_busy_in = 1'b0; get_inst_in = 1'b0;
        end
        if (ctl_mode == 1) begin
            if (ctl_cnt == 0) begin
                ctl_mode = 2; mem_busy_in = 1'b1; get_inst_in = 1'b1;
                inst_pc_in = ctl_pc; inst_in = mem_word(ctl_pc);
            end else begin
                ctl_cnt--;
            end
        end else if (if_req_out) begin
            if (rand_arb && arb_block == 0 && $urandom_range(0, 9) < 2)
                arb_block = $urandom_range(1, 3);
            if (arb_block > 0) begin
                arb_block--;
                mem_busy_in = 1'b1; get_inst_in = 1'b0; inst_pc_in = 32'h0000_FFFF;
            end else begin
                ctl_mode = 1; ctl_pc = addr_if_out; ctl_cnt = ctl_lat;
                mem_busy_in = 1'b1; get_inst_in = 1'b0; inst_pc_in = addr_if_out;
            end
        end else begin
            mem_busy_in = 1'b0; get_inst_in = 1'b0;
        end
    endtask

    // One clock; scoreboard the outputs, then let the controller react.
    task automatic tick();
        logic br, st, pv, preq;
        logic [31:0] tgt, ppc, pinst;
        br = branch_flag_in; st = stall_in; tgt = branch_target_in;
        pv = inst_valid_out; ppc = pc_out; pinst = inst_out; preq = if_req_out;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (br) begin
                check("br_vld", 32'(inst_valid_out), 32'(0));
                exp_pc = tgt;
            end else if (st) begin
                check("stall_vld", 32'(inst_valid_out), 32'(pv));
                check("stall_pc", pc_out, ppc);
                check("stall_inst", inst_out, pinst);
            end else if (inst_valid_out) begin
                check("dlv_pc", pc_out, exp_pc);
                check("dlv_inst", inst_out, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (if_req_out && !preq) check("req_addr", addr_if_out, exp_pc);
            if (if_req_out) check("req_stallreq", 32'(if_stall_req_out), 32'(1));
        end
        controller();
    endtask

    task automatic wait_delivery(input string tag, input int budget);
        int d0;
        d0 = deliveries;
        for (int n = 0; n < budget && deliveries == d0; n++) tick();
        check(tag, 32'(deliveries > d0), 32'(1));
    endtask

    task automatic wait_in_wait(input string tag, input int budget);
        for (int n = 0; n < budget && !(ctl_mode == 1 && !if_req_out && if_stall_req_out); n++) tick();
        check(tag, 32'(ctl_mode == 1 && !if_req_out && if_stall_req_out), 32'(1));
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int n = 0; n < budget && !if_req_out; n++) tick();
        check(tag, 32'(if_req_out), 32'(1));
    endtask

    task automatic wait_ctl_idle(input string tag, input int budget);
        for (int n = 0; n < budget && ctl_mode != 0; n++) tick();
        check(tag, 32'(ctl_mode), 32'(0));
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; branch_flag_in = 1'b0; branch_target_in = 32'h0;
        mem_busy_in = 1'b0; get_inst_in = 1'b0; inst_pc_in = 32'h0; inst_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(if_req_out), 32'(0));
        check("rst_addr", addr_if_out, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_vld", 32'(inst_valid_out), 32'(0));
        check("rst_stallreq", 32'(if_stall_req_out), 32'(0));
        rst = 1'b0;

        // Cold fetch of PC 0.
        ctl_lat = 5;
        tick();
        check("cold_req", 32'(if_req_out), 32'(1));
        check("cold_addr", addr_if_out, 32'h0);
        wait_delivery("cold_timeout", 40);
        check("cold_pc", pc_out, 32'h0);
        check("cold_inst", inst_out, 32'h13);

        // Warm hit after looping back to PC 0.
        branch_flag_in = 1'b1; branch_target_in = 32'h0;
        tick();
        branch_flag_in = 1'b0;
        tick();
        check("warm_vld", 32'(inst_valid_out), 32'(1));
        check("warm_pc", pc_out, 32'h0);
        check("warm_noreq", 32'(if_req_out), 32'(0));

        // Stall across the refill of PC 4, then a one-cycle hit.
        ctl_lat = 4;
        tick();
        check("stl_req", 32'(if_req_out), 32'(1));
        stall_in = 1'b1;
        wait_ctl_idle("stl_resp_timeout", 40);
        repeat (2) tick();
        check("stl_novld", 32'(inst_valid_out), 32'(0));
        stall_in = 1'b0;
        tick();
        check("stl_rel_vld", 32'(inst_valid_out), 32'(1));
        check("stl_rel_pc", pc_out, 32'h4);
        check("stl_rel_noreq", 32'(if_req_out), 32'(0));

        // Redirect to 0x100 while waiting for PC 8; next fetch loses arbitration.
        ctl_lat = 6;
        wait_in_wait("bw_wait_timeout", 20);
        check("bw_addr8", addr_if_out, 32'h8);
        branch_flag_in = 1'b1; branch_target_in = 32'h100; arb_block = 3;
        tick();
        branch_flag_in = 1'b0;
        check("bw_still_wait", 32'(if_stall_req_out), 32'(1));
        wait_req("bw_req_timeout", 40);
        check("bw_addr", addr_if_out, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arb_req", 32'(if_req_out), 32'(1));
            check("arb_addr", addr_if_out, 32'h100);
        end
        wait_delivery("arb_timeout", 40);
        check("arb_pc", pc_out, 32'h100);

        // PC 8 was refilled despite the discard.
        branch_flag_in = 1'b1; branch_target_in = 32'h8;
        tick();
        branch_flag_in = 1'b0;
        tick();
        check("bw_hit_vld", 32'(inst_valid_out), 32'(1));
        check("bw_hit_pc", pc_out, 32'h8);
        check("bw_hit_noreq", 32'(if_req_out), 32'(0));

        // Asynchronous reset between edges while in WAIT.
        wait_in_wait("ar_wait_timeout", 20);
        #2 rst = 1'b1;
        #1;
        check("ar_req", 32'(if_req_out), 32'(0));
        check("ar_addr", addr_if_out, 32'h0);
        check("ar_pc", pc_out, 32'h0);
        check("ar_inst", inst_out, 32'h0);
        check("ar_vld", 32'(inst_valid_out), 32'(0));
        check("ar_stallreq", 32'(if_stall_req_out), 32'(0));
        repeat (2) tick();
        exp_pc = 32'h0;
        rst = 1'b0;
        tick();
        check("ar_restart_req", 32'(if_req_out), 32'(1));
        check("ar_restart_addr", addr_if_out, 32'h0);
        wait_delivery("ar_restart_timeout", 40);
        check("ar_restart_inst", inst_out, 32'h13);

        // Random stalls, redirects (including a wrap target), latencies and arbitration.
        begin
            int d0;
            d0 = deliveries;
            rand_arb = 1'b1;
            for (int i = 0; i < 2000; i++) begin
                ctl_lat = $urandom_range(0, 6);
                stall_in = ($urandom_range(0, 99) < 20);
                branch_flag_in = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 9) == 0) branch_target_in = 32'hFFFF_FFF8;
                else branch_target_in = 32'($urandom_range(0, 255)) << 2;
                tick();
            end
            stall_in = 1'b0; branch_flag_in = 1'b0;
            check("rand_progress", 32'(deliveries - d0 > 50), 32'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
